// File: rtl/multi_base_calc_pkg.sv
// Shared encodings and helpers for the multi-channel baseline calculator.
package multi_base_calc_pkg;

    typedef enum logic [1:0] {
        EXEC_INIT = 2'b00,
        EXEC_TRG  = 2'b11
    } exec_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } calc_state_e;

    // Ceiling log2; clogb2(1) == 0.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/base_calc_channel.sv
// One ADC channel: lane adder (stage 1), window accumulator (stage 2),
// power-of-two divide and saturating threshold.
module base_calc_channel
    import multi_base_calc_pkg::*;
#(
    parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
    parameter int unsigned S_AXIS_TDATA_WIDTH   = 128,
    parameter int unsigned LOG2_WINDOW          = 20
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESET,
    input  logic                            clear,
    input  logic                            beat_en,
    input  logic                            s1_valid,
    input  logic                            s1_last,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   tdata,
    input  logic [ADC_RESOLUTION_WIDTH-1:0] offset,
    output logic [ADC_RESOLUTION_WIDTH-1:0] baseline,
    output logic [ADC_RESOLUTION_WIDTH-1:0] threshold
);

    localparam int unsigned SPT      = S_AXIS_TDATA_WIDTH / 16;
    localparam int unsigned LOG2_SPT = clogb2(SPT);
    localparam int unsigned SUM_W    = ADC_RESOLUTION_WIDTH + LOG2_SPT;
    localparam int unsigned ACC_W    = SUM_W + LOG2_WINDOW;
    localparam int unsigned SHIFT    = LOG2_SPT + LOG2_WINDOW;

    logic [SUM_W-1:0]                lane_sum;
    logic [SUM_W-1:0]                s1_sum;
    logic [ACC_W-1:0]                acc;
    logic [ACC_W-1:0]                total;
    logic [ADC_RESOLUTION_WIDTH-1:0] base_next;
    logic [ADC_RESOLUTION_WIDTH:0]   thr_sum;
    logic [ADC_RESOLUTION_WIDTH-1:0] thr_next;
    logic                            unused_bits;

    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < SPT; k++) begin
            lane_sum = lane_sum + SUM_W'(tdata[16*k +: ADC_RESOLUTION_WIDTH]);
        end
    end

    // The final beat is folded in combinationally so the result lands one
    // cycle after stage 1 instead of waiting for the accumulator to settle.
    always_comb begin
        total     = acc + ACC_W'(s1_sum);
        base_next = total[SHIFT +: ADC_RESOLUTION_WIDTH];
        thr_sum   = {1'b0, base_next} + {1'b0, offset};
        thr_next  = thr_sum[ADC_RESOLUTION_WIDTH] ? '1 : thr_sum[ADC_RESOLUTION_WIDTH-1:0];
    end

    always_comb begin
        unused_bits = ^total[SHIFT-1:0];
        for (int unsigned k = 0; k < SPT; k++) begin
            unused_bits ^= ^tdata[16*k+ADC_RESOLUTION_WIDTH +: 16-ADC_RESOLUTION_WIDTH];
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            s1_sum    <= '0;
            acc       <= '0;
            baseline  <= '0;
            threshold <= '0;
        end else begin
            if (clear) begin
                s1_sum <= '0;
            end else if (beat_en) begin
                s1_sum <= lane_sum;
            end

            if (clear) begin
                acc <= '0;
            end else if (s1_valid) begin
                acc <= s1_last ? '0 : total;
            end

            if (!clear && s1_valid && s1_last) begin
                baseline  <= base_next;
                threshold <= thr_next;
            end
        end
    end

endmodule

// File: rtl/multi_base_calc.sv
// Multi-channel ADC baseline averager: shared beat controller driving
// NUM_CH identical channel datapaths.
module multi_base_calc
    import multi_base_calc_pkg::*;
#(
    parameter int unsigned NUM_CH               = 2,
    parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
    parameter int unsigned S_AXIS_TDATA_WIDTH   = 128,
    parameter int unsigned LOG2_WINDOW          = 20,
    parameter bit          CONTINUOUS           = 1'b0
) (
    input  logic                                   AXIS_ACLK,
    input  logic                                   AXIS_ARESET,
    input  logic [1:0]                             EXEC_STATE,
    input  logic [NUM_CH*S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                                   S_AXIS_TVALID,
    input  logic [ADC_RESOLUTION_WIDTH-1:0]        I_THRESHOLD_OFFSET,
    input  logic                                   I_RESTART,
    output logic [NUM_CH*ADC_RESOLUTION_WIDTH-1:0] O_BASELINE,
    output logic [NUM_CH*ADC_RESOLUTION_WIDTH-1:0] O_THRESHOLD,
    output logic                                   O_BASELINE_UPDATE,
    output logic                                   O_CALC_COMPLETE
);

    calc_state_e            state;
    calc_state_e            state_next;
    logic [LOG2_WINDOW-1:0] beat_cnt;
    logic                   s1_valid;
    logic                   s1_last;
    logic                   in_init;
    logic                   abort;
    logic                   accept;
    logic                   last_beat;
    logic                   update_next;

    always_comb begin
        in_init     = (EXEC_STATE == EXEC_INIT);
        abort       = (state == ST_ACCUM) && (!in_init || I_RESTART);
        accept      = in_init && S_AXIS_TVALID && (state != ST_HOLD) && !abort;
        last_beat   = (beat_cnt == '1);
        update_next = s1_valid && s1_last && !abort;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (last_beat && !CONTINUOUS) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (accept && last_beat && !CONTINUOUS) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (I_RESTART) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter wraps naturally at the window boundary, which is exactly the
    // restart point needed for back-to-back windows.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state             <= ST_IDLE;
            beat_cnt          <= '0;
            s1_valid          <= 1'b0;
            s1_last           <= 1'b0;
            O_BASELINE_UPDATE <= 1'b0;
            O_CALC_COMPLETE   <= 1'b0;
        end else begin
            state <= state_next;
            if (abort) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            s1_valid          <= accept;
            s1_last           <= accept && last_beat;
            O_BASELINE_UPDATE <= update_next;
            O_CALC_COMPLETE   <= O_CALC_COMPLETE || update_next;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        base_calc_channel #(
            .ADC_RESOLUTION_WIDTH (ADC_RESOLUTION_WIDTH),
            .S_AXIS_TDATA_WIDTH   (S_AXIS_TDATA_WIDTH),
            .LOG2_WINDOW          (LOG2_WINDOW)
        ) u_ch (
            .AXIS_ACLK   (AXIS_ACLK),
            .AXIS_ARESET (AXIS_ARESET),
            .clear       (abort),
            .beat_en     (accept),
            .s1_valid    (s1_valid),
            .s1_last     (s1_last),
            .tdata       (S_AXIS_TDATA[c*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH]),
            .offset      (I_THRESHOLD_OFFSET),
            .baseline    (O_BASELINE[c*ADC_RESOLUTION_WIDTH +: ADC_RESOLUTION_WIDTH]),
            .threshold   (O_THRESHOLD[c*ADC_RESOLUTION_WIDTH +: ADC_RESOLUTION_WIDTH])
        );
    end

endmodule

// File: doc/multi_base_calc.md
MULTI_BASE_CALC -- requirements
Module: multi_base_calc

Interface
REQ-001 Parameter NUM_CH, 2: number of independent ADC channels.
REQ-002 Parameter ADC_RESOLUTION_WIDTH, 12: valid bits per 16-bit sample lane.
REQ-003 Parameter S_AXIS_TDATA_WIDTH, 128: per-channel bus width; SPT = S_AXIS_TDATA_WIDTH/16 samples per beat, power of two.
REQ-004 Parameter LOG2_WINDOW, 20: averaging window = 2^LOG2_WINDOW accepted beats.
REQ-005 Parameter CONTINUOUS, 0: 0 = one-shot window, 1 = back-to-back windows.
REQ-006 AXIS_ACLK  in  1  single clock; all logic rising-edge.
REQ-007 AXIS_ARESET  in  1  synchronous, active-high reset.
REQ-008 EXEC_STATE  in  2  system state; INIT=2'b00 enables calculation, TRG=2'b11.
REQ-009 S_AXIS_TDATA  in  NUM_CH*S_AXIS_TDATA_WIDTH  channel c at slice c*S_AXIS_TDATA_WIDTH.
REQ-010 S_AXIS_TVALID  in  1  shared beat-valid for all channels; no TREADY (always accepted).
REQ-011 I_THRESHOLD_OFFSET  in  ADC_RESOLUTION_WIDTH  unsigned offset added to each baseline.
REQ-012 I_RESTART  in  1  single-cycle request to discard current window and start a new one.
REQ-013 O_BASELINE  out  NUM_CH*ADC_RESOLUTION_WIDTH  per-channel averaged baseline.
REQ-014 O_THRESHOLD  out  NUM_CH*ADC_RESOLUTION_WIDTH  per-channel baseline+offset, saturated.
REQ-015 O_BASELINE_UPDATE  out  1  one-cycle pulse when O_BASELINE/O_THRESHOLD load new values.
REQ-016 O_CALC_COMPLETE  out  1  sticky flag: at least one full window completed since reset.

Function
REQ-017 Sample k of channel c SHALL be bits [16k +: ADC_RESOLUTION_WIDTH] of that channel's slice, unsigned.
REQ-018 A beat SHALL be accepted iff EXEC_STATE==INIT and S_AXIS_TVALID==1 and state is IDLE or ACCUM.
REQ-019 Stage 1: per channel, registered exact sum of SPT samples, width ADC_RESOLUTION_WIDTH+log2(SPT), plus valid/last flags.
REQ-020 Stage 2: per channel, exact accumulator, width ADC_RESOLUTION_WIDTH+log2(SPT)+LOG2_WINDOW; no overflow possible.
REQ-021 Beat counter, LOG2_WINDOW bits, counts accepted beats; the beat at count 2^LOG2_WINDOW-1 is tagged last.
REQ-022 On stage-1 last: baseline = (accumulator + stage-1 sum) >> (log2(SPT)+LOG2_WINDOW), floor; loaded into O_BASELINE.
REQ-023 Latency: last beat accepted in cycle t -> O_BASELINE, O_THRESHOLD updated and O_BASELINE_UPDATE=1 in cycle t+2.
REQ-024 O_THRESHOLD = min(baseline + I_THRESHOLD_OFFSET, 2^ADC_RESOLUTION_WIDTH-1), loaded in the same cycle as O_BASELINE.
REQ-025 O_CALC_COMPLETE SHALL rise with the first O_BASELINE_UPDATE and stay high until reset.
REQ-026 States: IDLE, ACCUM, HOLD; IDLE->ACCUM on first accepted beat.
REQ-027 ACCUM->HOLD on last beat if CONTINUOUS=0; if CONTINUOUS=1 stay ACCUM, counter wraps to 0, accumulator restarts from the next beat with no lost beats.
REQ-028 HOLD: no beats accepted; outputs held; HOLD->IDLE on I_RESTART.
REQ-029 TVALID low in ACCUM: pause, counter and accumulator hold.
REQ-030 EXEC_STATE!=INIT in ACCUM: abort; counter, accumulators, in-flight stage-1 data cleared; ->IDLE; outputs retain last values; no update pulse.
REQ-031 I_RESTART in ACCUM: same as abort, same cycle; I_RESTART simultaneous with a last beat: restart wins, no update.

Reset
REQ-032 On AXIS_ARESET: state IDLE; counter, accumulators, stage-1 registers 0; O_BASELINE, O_THRESHOLD 0; O_BASELINE_UPDATE 0; O_CALC_COMPLETE 0.
REQ-033 Reset mid-window SHALL discard all partial data; first window after reset needs full 2^LOG2_WINDOW beats.

Structure
REQ-034 Package multi_base_calc_pkg: EXEC_STATE encodings INIT/TRG, state enum, clogb2 function.
REQ-035 Sub-module base_calc_channel: per-channel sample adder, accumulator, divide, saturating threshold; instantiated NUM_CH times under one shared controller (FSM, counter).

Verification (SPT=8, LOG2_WINDOW=2, NUM_CH=2)
REQ-036 All lanes 0x100 ch0, 0x020 ch1, 4 consecutive beats -> cycle t+2: baseline 0x100/0x020, one-cycle update pulse, complete=1.
REQ-037 Lanes alternate 0x000/0xFFF, 4 beats -> baseline 0x7FF (floor of 2047.5).
REQ-038 Baseline 0xF00, offset 0x200 -> threshold 0xFFF; offset 0x010 -> 0xF10.
REQ-039 2 beats then EXEC_STATE=TRG, back to INIT, 4 beats of 0x040 -> no pulse after abort, baseline 0x040 after the 4 fresh beats.
REQ-040 TVALID gaps of 3 cycles between beats -> same result as gap-free; CONTINUOUS=1 with 0x100 then 0x200 windows -> two pulses, 0x100 then 0x200.
REQ-041 AXIS_ARESET asserted after 3 beats -> all outputs 0; next window needs 4 full beats.
